// File: rtl/boot_loader_seq.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_seq
// Brief    : Copies a boot image from SPI flash into program memory word by
//            word, sums it, and holds the CPU in reset until the copy ends.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader_seq #(
    parameter logic [31:0] SRC_BASE   = 32'h0010_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned TIMEOUT    = 4096,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        flash_ren,
    output logic [31:0] flash_addr,
    input  logic [31:0] flash_data,
    input  logic        flash_valid,
    output logic        pm_wen,
    output logic [31:0] pm_addr,
    output logic [31:0] pm_data,
    output logic [3:0]  pm_byte_select,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    localparam int unsigned c_idx_w = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic [c_tmo_w-1:0] tmo_q, tmo_d;
    logic               flash_ren_q, flash_ren_d;
    logic [31:0]        flash_addr_q, flash_addr_d;
    logic               pm_wen_q, pm_wen_d;
    logic [31:0]        pm_addr_q, pm_addr_d;
    logic [31:0]        pm_data_q, pm_data_d;
    logic [3:0]         pm_byte_select_q, pm_byte_select_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [31:0]        checksum_q, checksum_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            tmo_q            <= '0;
            flash_ren_q      <= 1'b0;
            flash_addr_q     <= 32'h0;
            pm_wen_q         <= 1'b0;
            pm_addr_q        <= 32'h0;
            pm_data_q        <= 32'h0;
            pm_byte_select_q <= 4'h0;
            cpu_hold_q       <= 1'b1;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            checksum_q       <= 32'h0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            tmo_q            <= tmo_d;
            flash_ren_q      <= flash_ren_d;
            flash_addr_q     <= flash_addr_d;
            pm_wen_q         <= pm_wen_d;
            pm_addr_q        <= pm_addr_d;
            pm_data_q        <= pm_data_d;
            pm_byte_select_q <= pm_byte_select_d;
            cpu_hold_q       <= cpu_hold_d;
            done_q           <= done_d;
            error_q          <= error_d;
            checksum_q       <= checksum_d;
        end
    end

    // Outputs are computed one state ahead so each one is visible in the
    // state that owns it (flash_ren in WAIT, pm_wen in WRITE, done in DONE).
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        tmo_d            = tmo_q;
        flash_ren_d      = flash_ren_q;
        flash_addr_d     = flash_addr_q;
        pm_wen_d         = 1'b0;
        pm_addr_d        = pm_addr_q;
        pm_data_d        = pm_data_q;
        pm_byte_select_d = 4'h0;
        cpu_hold_d       = cpu_hold_q;
        done_d           = done_q;
        error_d          = error_q;
        checksum_d       = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_d    = S_REQ;
                    idx_d      = '0;
                    checksum_d = 32'h0;
                end
            end
            S_REQ: begin
                flash_ren_d  = 1'b1;
                flash_addr_d = SRC_BASE + (32'(idx_q) << 2);
                tmo_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // A valid on the final allowed cycle still beats the timeout.
                if (flash_valid) begin
                    flash_ren_d = 1'b0;
                    pm_wen_d    = 1'b1;
                    pm_addr_d   = DST_BASE + (32'(idx_q) << 2);
                    pm_data_d   = flash_data;
                    state_d     = S_WRITE;
                end else if (tmo_q == c_tmo_last) begin
                    flash_ren_d = 1'b0;
                    error_d     = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q + pm_data_q;
                if (idx_q == c_last_idx) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    idx_d   = idx_q + c_idx_w'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pm_wen_d) begin
            pm_byte_select_d = 4'hF;
        end
    end

    assign flash_ren      = flash_ren_q;
    assign flash_addr     = flash_addr_q;
    assign pm_wen         = pm_wen_q;
    assign pm_addr        = pm_addr_q;
    assign pm_data        = pm_data_q;
    assign pm_byte_select = pm_byte_select_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader_seq
// Brief    : Directed, table-driven bench for boot_loader_seq (auto and manual
//            start instances sharing one clock).
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader_seq;

    typedef struct {
        int          k;
        logic [31:0] data;
        logic [31:0] faddr;
        logic [31:0] paddr;
        logic [31:0] ck_pre;
    } vec_t;

    logic        clk;
    int          cyc;
    int          checks;
    int          errors;
    logic        sel_m;
    logic        f_valid;
    logic [31:0] f_data;

    logic        a_reset, a_start, a_flash_ren, a_flash_valid, a_pm_wen;
    logic        a_cpu_hold, a_done, a_error;
    logic [31:0] a_flash_addr, a_flash_data, a_pm_addr, a_pm_data, a_checksum;
    logic [3:0]  a_bs;

    logic        m_reset, m_start, m_flash_ren, m_flash_valid, m_pm_wen;
    logic        m_cpu_hold, m_done, m_error;
    logic [31:0] m_flash_addr, m_flash_data, m_pm_addr, m_pm_data, m_checksum;
    logic [3:0]  m_bs;

    logic        s_ren, s_pm_wen, s_hold, s_done, s_err;
    logic [31:0] s_faddr, s_pm_addr, s_pm_data, s_ck;
    logic [3:0]  s_bs;

    boot_loader_seq #(
        .SRC_BASE(32'h100), .DST_BASE(32'h40), .WORDS(3), .TIMEOUT(8), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .reset(a_reset), .start(a_start),
        .flash_ren(a_flash_ren), .flash_addr(a_flash_addr),
        .flash_data(a_flash_data), .flash_valid(a_flash_valid),
        .pm_wen(a_pm_wen), .pm_addr(a_pm_addr), .pm_data(a_pm_data),
        .pm_byte_select(a_bs), .cpu_hold(a_cpu_hold), .done(a_done),
        .error(a_error), .checksum(a_checksum)
    );

    boot_loader_seq #(
        .SRC_BASE(32'h0010_0000), .DST_BASE(32'h0), .WORDS(2), .TIMEOUT(8), .AUTO_START(1'b0)
    ) dut_m (
        .clk(clk), .reset(m_reset), .start(m_start),
        .flash_ren(m_flash_ren), .flash_addr(m_flash_addr),
        .flash_data(m_flash_data), .flash_valid(m_flash_valid),
        .pm_wen(m_pm_wen), .pm_addr(m_pm_addr), .pm_data(m_pm_data),
        .pm_byte_select(m_bs), .cpu_hold(m_cpu_hold), .done(m_done),
        .error(m_error), .checksum(m_checksum)
    );

    assign a_flash_valid = sel_m ? 1'b0 : f_valid;
    assign m_flash_valid = sel_m ? f_valid : 1'b0;
    assign a_flash_data  = f_data;
    assign m_flash_data  = f_data;

    assign s_ren     = sel_m ? m_flash_ren  : a_flash_ren;
    assign s_faddr   = sel_m ? m_flash_addr : a_flash_addr;
    assign s_pm_wen  = sel_m ? m_pm_wen     : a_pm_wen;
    assign s_pm_addr = sel_m ? m_pm_addr    : a_pm_addr;
    assign s_pm_data = sel_m ? m_pm_data    : a_pm_data;
    assign s_bs      = sel_m ? m_bs         : a_bs;
    assign s_hold    = sel_m ? m_cpu_hold   : a_cpu_hold;
    assign s_done    = sel_m ? m_done       : a_done;
    assign s_err     = sel_m ? m_error      : a_error;
    assign s_ck      = sel_m ? m_checksum   : a_checksum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_flash_ren",  32'(s_ren),    32'd0);
        chk("rst_flash_addr", s_faddr,       32'd0);
        chk("rst_pm_wen",     32'(s_pm_wen), 32'd0);
        chk("rst_pm_addr",    s_pm_addr,     32'd0);
        chk("rst_pm_data",    s_pm_data,     32'd0);
        chk("rst_pm_bs",      32'(s_bs),     32'd0);
        chk("rst_cpu_hold",   32'(s_hold),   32'd1);
        chk("rst_done",       32'(s_done),   32'd0);
        chk("rst_error",      32'(s_err),    32'd0);
        chk("rst_checksum",   s_ck,          32'd0);
    endtask

    task automatic wait_ren();
        int n;
        n = 0;
        while (s_ren !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ren_rise_bound", 32'(s_ren), 32'd1);
    endtask

    // One word: WAIT for k cycles, valid on the k-th, then check the WRITE.
    task automatic run_word(input vec_t v, input bit stray);
        logic ok;
        wait_ren();
        chk("flash_addr", s_faddr, v.faddr);
        chk("checksum_pre", s_ck, v.ck_pre);
        ok = 1'b1;
        for (int i = 1; i < v.k; i++) begin
            tick();
            if (s_ren !== 1'b1 || s_pm_wen !== 1'b0 || s_err !== 1'b0 || s_faddr !== v.faddr)
                ok = 1'b0;
        end
        chk("wait_stable", 32'(ok), 32'd1);
        f_valid = 1'b1;
        f_data  = v.data;
        tick();
        f_valid = 1'b0;
        f_data  = 32'hDEAD_BEEF;
        chk("pm_wen",   32'(s_pm_wen), 32'd1);
        chk("pm_addr",  s_pm_addr,     v.paddr);
        chk("pm_data",  s_pm_data,     v.data);
        chk("pm_bs",    32'(s_bs),     32'hF);
        chk("ren_drop", 32'(s_ren),    32'd0);
        if (stray) begin
            f_valid = 1'b1;
            f_data  = 32'hBAD0_0000;
            tick();
            chk("stray_no_dup_wen", 32'(s_pm_wen), 32'd0);
            tick();
            f_valid = 1'b0;
            chk("stray_pm_data_kept", s_pm_data, v.data);
        end
    endtask

    vec_t tab [3];
    vec_t mtab [2];
    vec_t v;
    int   t0;
    logic ok;

    initial begin
        checks  = 0;
        errors  = 0;
        sel_m   = 1'b0;
        f_valid = 1'b0;
        f_data  = 32'h0;
        a_reset = 1'b1;
        m_reset = 1'b1;
        a_start = 1'b0;
        m_start = 1'b0;

        tab[0]  = '{5, 32'h11, 32'h100, 32'h40, 32'h00};
        tab[1]  = '{5, 32'h22, 32'h104, 32'h44, 32'h11};
        tab[2]  = '{5, 32'h33, 32'h108, 32'h48, 32'h33};
        mtab[0] = '{1, 32'hFFFF_FFFF, 32'h0010_0000, 32'h0, 32'h0};
        mtab[1] = '{3, 32'h0000_0002, 32'h0010_0004, 32'h4, 32'hFFFF_FFFF};

        // Reset state and three-word copy with auto start
        tick();
        tick();
        chk_reset();
        a_reset = 1'b0;
        tick();
        chk("auto_ren_lat1", 32'(s_ren), 32'd0);
        tick();
        chk("auto_ren_lat2", 32'(s_ren), 32'd1);
        t0 = cyc;
        for (int w = 0; w < 3; w++) run_word(tab[w], 1'b0);
        chk("last_write_done", 32'(s_done), 32'd0);
        chk("last_write_hold", 32'(s_hold), 32'd1);
        tick();
        chk("copy_done",     32'(s_done),   32'd1);
        chk("copy_hold",     32'(s_hold),   32'd0);
        chk("copy_checksum", s_ck,          32'h66);
        chk("copy_error",    32'(s_err),    32'd0);
        chk("copy_ren",      32'(s_ren),    32'd0);
        chk("copy_time",     32'(cyc - t0), 32'd20);
        repeat (5) tick();
        chk("done_sticky", 32'(s_done), 32'd1);
        chk("done_pm_wen", 32'(s_pm_wen), 32'd0);

        // Reset in the WAIT of word 1, then a full restart from word 0
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        v = '{2, 32'hAAAA_0000, 32'h100, 32'h40, 32'h0};
        run_word(v, 1'b0);
        wait_ren();
        chk("midrst_faddr", s_faddr, 32'h104);
        tick();
        a_reset = 1'b1;
        tick();
        chk_reset();
        a_reset = 1'b0;
        for (int w = 0; w < 3; w++) run_word(tab[w], 1'b0);
        tick();
        chk("restart_done", 32'(s_done), 32'd1);
        chk("restart_checksum", s_ck, 32'h66);

        // Valid on the last allowed WAIT cycle, stray valids, then a timeout
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        v = '{8, 32'h1234_5678, 32'h100, 32'h40, 32'h0};
        run_word(v, 1'b1);
        wait_ren();
        chk("tmo_faddr", s_faddr, 32'h104);
        chk("tmo_ck_pre", s_ck, 32'h1234_5678);
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (s_ren !== 1'b1 || s_err !== 1'b0 || s_pm_wen !== 1'b0) ok = 1'b0;
        end
        chk("tmo_wait_stable", 32'(ok), 32'd1);
        tick();
        chk("tmo_error", 32'(s_err),  32'd1);
        chk("tmo_ren",   32'(s_ren),  32'd0);
        chk("tmo_hold",  32'(s_hold), 32'd1);
        chk("tmo_done",  32'(s_done), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_pm_wen !== 1'b0 || s_err !== 1'b1 || s_ren !== 1'b0 || s_hold !== 1'b1) ok = 1'b0;
        end
        chk("err_sticky_quiet", 32'(ok), 32'd1);

        // Manual start instance, checksum wrap
        sel_m = 1'b1;
        tick();
        chk_reset();
        m_reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_ren !== 1'b0 || s_hold !== 1'b1) ok = 1'b0;
        end
        chk("manual_idle", 32'(ok), 32'd1);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        chk("manual_ren_req", 32'(s_ren), 32'd0);
        tick();
        chk("manual_ren_wait", 32'(s_ren), 32'd1);
        for (int w = 0; w < 2; w++) run_word(mtab[w], 1'b0);
        tick();
        chk("wrap_done",     32'(s_done), 32'd1);
        chk("wrap_checksum", s_ck,        32'h0000_0001);
        chk("wrap_hold",     32'(s_hold), 32'd0);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        tick();
        chk("start_after_done_ren",  32'(s_ren),  32'd0);
        chk("start_after_done_done", 32'(s_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_loader_seq.md
# boot_loader_seq

Boot sequencer that copies a program image from SPI flash into program memory before the CPU runs. It drives the flash controller's read port and the program-memory write port one word at a time, accumulates a 32-bit additive checksum, and holds the CPU in reset (`cpu_hold`) until the copy ends. It sits between the top-level reset logic, the flash controller and program memory. After completion it releases both ports so the bus can drive them.

## Interface
Parameters:
- `SRC_BASE`, 32'h0010_0000: flash byte address of the first image word.
- `DST_BASE`, 32'h0000_0000: program-memory byte address of the first word.
- `WORDS`, 1024: number of 32-bit words to copy; must be ≥1.
- `TIMEOUT`, 4096: maximum cycles to wait for `flash_valid` per word.
- `AUTO_START`, 1: if 1, the copy starts on the first cycle after reset; if 0, it waits for `start`.

Ports:
- `clk` input 1: single clock domain, the CPU clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle start pulse; used only when `AUTO_START`=0.
- `flash_ren` output 1: read request to the flash controller, held until `flash_valid`.
- `flash_addr` output 32: byte address of the flash read.
- `flash_data` input 32: read data, sampled when `flash_valid`=1.
- `flash_valid` input 1: one-cycle pulse marking `flash_data` valid.
- `pm_wen` output 1: program-memory write strobe, one cycle per word.
- `pm_addr` output 32: program-memory byte address.
- `pm_data` output 32: write data.
- `pm_byte_select` output 4: constant 4'hF while `pm_wen`=1, otherwise 4'h0.
- `cpu_hold` output 1: keeps the CPU in reset while 1.
- `done` output 1: copy finished successfully (sticky).
- `error` output 1: a flash read timed out (sticky).
- `checksum` output 32: running sum mod 2^32 of all words written.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE, ERR.
- IDLE:
  - `cpu_hold`=1.
  - Go to REQ if `AUTO_START`=1, or if `start`=1.
  - On entry to REQ: word index = 0, `checksum` = 0.
- REQ:
  - Assert `flash_ren` with `flash_addr` = `SRC_BASE` + 4×index.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Keep `flash_ren` and `flash_addr` stable; increment the timeout counter.
  - On `flash_valid`=1: latch `flash_data`, drop `flash_ren`, go to WRITE.
  - If the counter reaches `TIMEOUT`-1 with no valid: go to ERR.
- WRITE:
  - One cycle with `pm_wen`=1, `pm_addr` = `DST_BASE` + 4×index, `pm_data` = latched word.
  - `checksum` += word.
  - If index = `WORDS`-1, go to DONE; otherwise increment index and go to REQ.
- DONE: `done`=1, `cpu_hold`=0. Stays here until reset; `start` is ignored.
- ERR: `error`=1, `cpu_hold`=1. Stays here until reset.
- Address arithmetic is 32-bit and wraps modulo 2^32; no bounds checking.
- The index counter is $clog2(`WORDS`) bits wide (at least 1 bit).
- `flash_valid` arriving outside WAIT is ignored.
- `flash_valid` on the same cycle as the timeout limit is accepted; valid wins.
- `start` pulses received after leaving IDLE are ignored.

## Timing
- Reset values:
  - State IDLE, index 0, timeout counter 0.
  - `flash_ren`=0, `flash_addr`=0, `pm_wen`=0, `pm_addr`=0, `pm_data`=0, `pm_byte_select`=0.
  - `cpu_hold`=1, `done`=0, `error`=0, `checksum`=0.
- All outputs are registered.
- Reset during any state aborts immediately: next cycle all outputs are at reset values. A partial copy is not undone.
- Per-word latency: REQ (1) + WAIT (k, where `flash_valid` arrives k cycles after `flash_ren` rises, 1 ≤ k ≤ `TIMEOUT`) + WRITE (1) = k+2 cycles.
- `cpu_hold` falls on the cycle after the last `pm_wen` pulse. `checksum` is final when `done` rises.
- With `AUTO_START`=1, `flash_ren` first rises 2 cycles after `reset` is deasserted.

## Test plan
- Three-word copy:
  - Setup: `WORDS`=3, `SRC_BASE`=32'h100, `DST_BASE`=32'h40; flash model returns 32'h11, 32'h22, 32'h33 with k=5.
  - Expect: `pm_wen` pulses at 32'h40, 32'h44, 32'h48 with those data, `pm_byte_select`=4'hF.
  - Expect: `checksum`=32'h66, `done`=1, `cpu_hold` falls, total copy time 21 cycles.
- Timeout:
  - Setup: `TIMEOUT`=8; flash never asserts valid on word 1.
  - Expect: `error`=1 after 8 WAIT cycles, `cpu_hold` stays 1, no further `pm_wen`, `flash_ren`=0.
- Manual start:
  - Setup: `AUTO_START`=0; hold 50 cycles with no `start`.
  - Expect: no `flash_ren` during those 50 cycles; after a `start` pulse, `flash_ren` rises on the cycle following the REQ cycle.
- Checksum wrap:
  - Setup: words 32'hFFFF_FFFF and 32'h0000_0002.
  - Expect: `checksum`=32'h0000_0001.
- Mid-copy reset:
  - Setup: assert `reset` for 1 cycle during WAIT of word 1.
  - Expect: all outputs at reset values the next cycle, then the copy restarts from word 0 at `SRC_BASE`.
- Boundary valid:
  - Setup: `flash_valid` arrives on the exact cycle the timeout counter reaches `TIMEOUT`-1.
  - Expect: word accepted, no error.
  - Setup: stray `flash_valid` pulses during WRITE.
  - Expect: ignored, no duplicate `pm_wen`.
